// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array result path.
// Holds the drain FSM encoding and the fixed-point format split.
package sa_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } drain_state_e;

    // Fixed-point word: sign, integer and fraction bits, array-wide.
    localparam int FX_W      = 8;
    localparam int FX_SIGN_W = 1;
    localparam int FX_INT_W  = 2;
    localparam int FX_FRAC_W = FX_W - FX_SIGN_W - FX_INT_W;

    function automatic int row_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/sa_tile_buffer.sv
// Local copy of one SA_R x SA_C result tile.
// Whole-tile capture, synchronous clear and a row-select read port.
module sa_tile_buffer
    import sa_pkg::*;
#(
    parameter int D_W  = 8,
    parameter int SA_R = 16,
    parameter int SA_C = 16
) (
    input  logic                                  I_CLK,
    input  logic                                  I_ASYN_RSTN,
    input  logic                                  i_clr,
    input  logic                                  i_cap,
    input  logic [0:SA_R-1][0:SA_C-1][D_W-1:0]    i_tile,
    input  logic [row_w(SA_R)-1:0]                i_sel,
    output logic [0:SA_C-1][D_W-1:0]              o_row
);

    logic [0:SA_R-1][0:SA_C-1][D_W-1:0] r_mem;

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            r_mem <= '0;
        end else if (i_clr) begin
            r_mem <= '0;
        end else if (i_cap) begin
            r_mem <= i_tile;
        end
    end

    always_comb begin
        o_row = '0;
        for (int r = 0; r < SA_R; r++) begin
            if (i_sel == row_w(SA_R)'(r)) begin
                o_row = r_mem[r];
            end
        end
    end

endmodule

// File: rtl/sa_result_drain.sv
// Captures the wrapper's result tile, frees the array, streams rows out.
// Define SA_DRAIN_RELU_EN to zero negative words on the read path.
module sa_result_drain
    import sa_pkg::*;
#(
    parameter int D_W   = 8,
    parameter int SA_R  = 16,
    parameter int SA_C  = 16,
    parameter int CNT_W = 16
) (
    input  logic                                  I_CLK,
    input  logic                                  I_ASYN_RSTN,
    input  logic                                  I_SYNC_RSTN,
    input  logic                                  I_SA_OUT_VLD,
    input  logic [0:SA_R-1][0:SA_C-1][D_W-1:0]    I_SA_OUT,
    output logic                                  O_SA_SYNC_RSTN,
    output logic                                  O_BUSY,
    output logic                                  O_ROW_VLD,
    input  logic                                  I_ROW_RDY,
    output logic [0:SA_C-1][D_W-1:0]              O_ROW_DATA,
    output logic [row_w(SA_R)-1:0]                O_ROW_IDX,
    output logic                                  O_ROW_LAST,
    output logic                                  O_TILE_DONE,
    output logic [CNT_W-1:0]                      O_TILE_CNT
);

    localparam int IDX_W = row_w(SA_R);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SA_R - 1);

    drain_state_e r_state;
    drain_state_e w_state_nxt;

    logic [IDX_W-1:0]         r_ptr;
    logic                     r_sync_rstn;
    logic                     r_done;
    logic [CNT_W-1:0]         r_cnt;

    logic                     w_clr;
    logic                     w_cap;
    logic                     w_acc;
    logic                     w_last_acc;
    logic                     w_is_last;
    logic [0:SA_C-1][D_W-1:0] w_buf_row;
    logic [0:SA_C-1][D_W-1:0] w_row_data;

    assign w_clr      = ~I_SYNC_RSTN;
    assign w_is_last  = (r_ptr == LAST_IDX);
    assign w_cap      = (r_state == S_IDLE) & I_SA_OUT_VLD & ~w_clr;
    assign w_acc      = (r_state == S_SEND) & I_ROW_RDY;
    assign w_last_acc = w_acc & w_is_last;

    sa_tile_buffer #(
        .D_W  (D_W),
        .SA_R (SA_R),
        .SA_C (SA_C)
    ) u_buf (
        .I_CLK       (I_CLK),
        .I_ASYN_RSTN (I_ASYN_RSTN),
        .i_clr       (w_clr),
        .i_cap       (w_cap),
        .i_tile      (I_SA_OUT),
        .i_sel       (r_ptr),
        .o_row       (w_buf_row)
    );

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_clr) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (I_SA_OUT_VLD) w_state_nxt = S_SEND;
                S_SEND: if (w_last_acc)   w_state_nxt = S_IDLE;
                default:                  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Pointer, wrapper-clear pulse, done pulse and tile counter.
    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            r_ptr       <= '0;
            r_sync_rstn <= 1'b1;
            r_done      <= 1'b0;
            r_cnt       <= '0;
        end else if (w_clr) begin
            r_ptr       <= '0;
            r_sync_rstn <= 1'b1;
            r_done      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_sync_rstn <= ~w_cap;
            r_done      <= w_last_acc;
            if (w_cap || w_last_acc) begin
                r_ptr <= '0;
            end else if (w_acc) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (w_last_acc) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_row_data = w_buf_row;
`ifdef SA_DRAIN_RELU_EN
        for (int c = 0; c < SA_C; c++) begin
            if (w_buf_row[c][D_W-1]) begin
                w_row_data[c] = '0;
            end
        end
`endif
    end

    always_comb begin
        O_ROW_VLD      = (r_state == S_SEND);
        O_BUSY         = (r_state == S_SEND);
        O_ROW_LAST     = (r_state == S_SEND) & w_is_last;
        O_ROW_IDX      = r_ptr;
        O_ROW_DATA     = w_row_data;
        O_SA_SYNC_RSTN = r_sync_rstn;
        O_TILE_DONE    = r_done;
        O_TILE_CNT     = r_cnt;
    end

endmodule

// File: tb/tb_sa_result_drain.sv
// Scoreboard bench for sa_result_drain with a behavioural wrapper model.
// Define SA_DRAIN_RELU_EN to match a ReLU build of the design.
module tb_sa_result_drain;

    localparam int D_W   = 8;
    localparam int SA_R  = 16;
    localparam int SA_C  = 16;
    localparam int CNT_W = 2;

    typedef logic [0:SA_C-1][D_W-1:0]           row_t;
    typedef logic [0:SA_R-1][0:SA_C-1][D_W-1:0] tile_t;
    typedef struct {
        row_t d;
        int   idx;
        bit   last;
    } beat_t;

    logic             clk;
    logic             rst_n;
    logic             sync_n;
    logic             sa_vld;
    tile_t            sa_out;
    logic             o_sync;
    logic             o_busy;
    logic             o_vld;
    logic             rdy;
    row_t             o_data;
    logic [3:0]       o_idx;
    logic             o_last;
    logic             o_done;
    logic [CNT_W-1:0] o_cnt;

    sa_result_drain #(
        .D_W   (D_W),
        .SA_R  (SA_R),
        .SA_C  (SA_C),
        .CNT_W (CNT_W)
    ) dut (
        .I_CLK          (clk),
        .I_ASYN_RSTN    (rst_n),
        .I_SYNC_RSTN    (sync_n),
        .I_SA_OUT_VLD   (sa_vld),
        .I_SA_OUT       (sa_out),
        .O_SA_SYNC_RSTN (o_sync),
        .O_BUSY         (o_busy),
        .O_ROW_VLD      (o_vld),
        .I_ROW_RDY      (rdy),
        .O_ROW_DATA     (o_data),
        .O_ROW_IDX      (o_idx),
        .O_ROW_LAST     (o_last),
        .O_TILE_DONE    (o_done),
        .O_TILE_CNT     (o_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    loaded = 0;
    int    sync_lows = 0;
    int    model_cnt = 0;
    bit    pend_done = 0;
    beat_t exp_q[$];
    tile_t tile_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [255:0] act,
                         input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic row_t model_row(input tile_t t, input int r);
        row_t x;
        for (int c = 0; c < SA_C; c++) begin
            x[c] = t[r][c];
`ifdef SA_DRAIN_RELU_EN
            if ($signed(x[c]) < 0) x[c] = '0;
`endif
        end
        return x;
    endfunction

    function automatic tile_t rand_tile();
        tile_t t;
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++)
                t[r][c] = D_W'($urandom);
        return t;
    endfunction

    // Wrapper model: holds valid until its clear arrives, then frees up.
    initial begin
        tile_t t;
        int    n;
        forever begin
            tick();
            if (rst_n && !sa_vld && tile_q.size() > 0) begin
                t = tile_q.pop_front();
                sa_out = t;
                sa_vld = 1'b1;
                loaded++;
                for (int r = 0; r < SA_R; r++)
                    exp_q.push_back('{model_row(t, r), r, r == SA_R - 1});
                n = 0;
                while (o_sync !== 1'b0 && n < 200) begin
                    tick();
                    n++;
                end
                if (n >= 200) begin
                    checks++;
                    errors++;
                    $display("FAIL wrapper_clear: got no clear after %0d cycles", n);
                end
                tick();
                sa_vld = 1'b0;
            end
        end
    end

    // Monitor: pops expected beats on each accept and tracks done/count.
    initial begin
        beat_t b;
        logic  prev_vld  = 0;
        logic  prev_rdy  = 0;
        logic  prev_sync = 1;
        logic  prev_clr  = 0;
        row_t  prev_data = '0;
        logic [3:0] prev_idx = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pend_done || o_done) begin
                    check("tile_done", 256'(o_done), 256'(pend_done));
                    if (pend_done) begin
                        model_cnt = (model_cnt + 1) % (1 << CNT_W);
                        check("tile_cnt", 256'(o_cnt), 256'(model_cnt));
                    end
                    pend_done = 0;
                end
                if (!o_sync) begin
                    sync_lows++;
                    check("sync_pulse", 256'({prev_sync, o_vld, o_idx}),
                          256'({1'b1, 1'b1, 4'd0}));
                end
                if (prev_vld && !prev_rdy && !prev_clr)
                    check("hold", 256'({o_vld, o_idx, o_data}),
                          256'({1'b1, prev_idx, prev_data}));
                if (o_vld && rdy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL beat_unexpected: got idx %0d expected none", o_idx);
                    end else begin
                        b = exp_q.pop_front();
                        check("row_data", 256'(o_data), 256'(b.d));
                        check("row_idx_last", 256'({o_idx, o_last}),
                              256'({4'(b.idx), b.last}));
                        if (b.last && sync_n) pend_done = 1;
                    end
                end
                if (!sync_n) begin
                    model_cnt = 0;
                    pend_done = 0;
                end
                prev_vld  = o_vld;
                prev_rdy  = rdy;
                prev_sync = o_sync;
                prev_clr  = !sync_n;
                prev_data = o_data;
                prev_idx  = o_idx;
            end
        end
    end

    task automatic wait_vld(input string nm);
        int n = 0;
        while (!o_vld && n < 50) begin
            tick();
            n++;
        end
        if (!o_vld) begin
            checks++;
            errors++;
            $display("FAIL %s: got no beat expected a beat within 50 cycles", nm);
        end
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!o_done && n < 300) begin
            rdy = ($urandom_range(0, 2) != 0);
            tick();
            n++;
        end
        if (!o_done) begin
            checks++;
            errors++;
            $display("FAIL %s: got no done expected done within 300 cycles", nm);
        end
        rdy = 1'b1;
    endtask

    initial begin
        tile_t t;
        int    n;
        int    done_t[$];
        int    exp_cnt[5];
        exp_cnt[0] = 1; exp_cnt[1] = 2; exp_cnt[2] = 3;
        exp_cnt[3] = 0; exp_cnt[4] = 1;
        rst_n  = 1'b0;
        sync_n = 1'b1;
        sa_vld = 1'b0;
        sa_out = '0;
        rdy    = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            check("reset_vals",
                  256'({o_vld, o_last, o_done, o_busy, o_sync, o_idx, o_cnt, o_data}),
                  256'({5'b00001, 4'd0, 2'd0, 128'd0}));
        end

        // Abort during row 5, while the counter is still 0.
        tile_q.push_back(rand_tile());
        wait_vld("clr_start");
        n = 0;
        while (o_idx != 4'd5 && n < 30) begin
            tick();
            n++;
        end
        check("clr_reach_row5", 256'(o_idx), 256'(5));
        rdy    = 1'b0;
        sync_n = 1'b0;
        tick();
        sync_n = 1'b1;
        exp_q.delete();
        check("clr_outputs", 256'({o_vld, o_busy, o_done, o_cnt}), 256'(0));
        check("clr_data", 256'(o_data), 256'(0));
        rdy = 1'b1;
        repeat (5) tick();
        check("clr_no_done_cnt", 256'({o_done, o_cnt}), 256'(0));

        // Basic drain with r*16+c pattern and full-rate ready.
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++)
                t[r][c] = D_W'(r * 16 + c);
        tile_q.push_back(t);
        wait_vld("basic_start");
        for (int k = 1; k <= 17; k++) begin
            check("basic_timing",
                  256'({o_vld, o_last, o_done, o_sync}),
                  256'({k <= 16, k == 16, k == 17, k != 1}));
            if (k <= 16) check("basic_idx", 256'(o_idx), 256'(k - 1));
            if (k == 4) check("basic_r3w5", 256'(o_data[5]), 256'(8'h35));
            if (k < 17) tick();
        end
        check("basic_cnt", 256'(o_cnt), 256'(1));

        // Alternating ready: 31 cycles of beats, done on the 32nd.
        tile_q.push_back(rand_tile());
        wait_vld("bp_start");
        for (int k = 1; k <= 32; k++) begin
            rdy = (k % 2 == 1);
            check("bp_timing", 256'({o_vld, o_done}),
                  256'({k <= 31, k == 32}));
            if (k < 32) tick();
        end
        rdy = 1'b1;
        tick();

        // Negative-word handling on the read path.
        t = rand_tile();
        t[2][3] = 8'h80;
        t[2][4] = 8'h7F;
        tile_q.push_back(t);
        wait_vld("relu_start");
        n = 0;
        while (o_idx != 4'd2 && n < 20) begin
            tick();
            n++;
        end
`ifdef SA_DRAIN_RELU_EN
        check("relu_80", 256'(o_data[3]), 256'(8'h00));
`else
        check("relu_80", 256'(o_data[3]), 256'(8'h80));
`endif
        check("relu_7f", 256'(o_data[4]), 256'(8'h7F));
        wait_done("relu_done");
        tick();

        for (int i = 0; i < 6; i++) begin
            tile_q.push_back(rand_tile());
            wait_vld("rand_start");
            wait_done("rand_done");
            repeat ($urandom_range(1, 3)) tick();
        end

        // Idle clear zeroes the counter, then five tiles back to back.
        sync_n = 1'b0;
        tick();
        sync_n = 1'b1;
        check("idle_clr_cnt", 256'(o_cnt), 256'(0));
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) tile_q.push_back(rand_tile());
        n = 0;
        while (done_t.size() < 5 && n < 200) begin
            tick();
            n++;
            if (o_done) begin
                check("b2b_cnt", 256'(o_cnt), 256'(exp_cnt[done_t.size()]));
                done_t.push_back(cyc);
            end
        end
        check("b2b_tiles", 256'(done_t.size()), 256'(5));
        for (int i = 1; i < done_t.size(); i++)
            check("b2b_period", 256'(done_t[i] - done_t[i-1]), 256'(17));

        repeat (3) tick();
        check("queue_empty", 256'(exp_q.size()), 256'(0));
        check("sync_pulses", 256'(sync_lows), 256'(loaded));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
